instr_encoder_loader: RTL and testbench

- Sequential instruction encoder and program loader. It is the write-side counterpart of the opcode decode in the control path.
- It accepts decoded instruction fields over a valid/ready stream and validates the format/opcode pairing.
- It packs each accepted instruction into a 32-bit instruction word and writes it into instruction memory through a request/acknowledge port at consecutive word addresses.
- It is used by the test harness and boot path to fill instruction memory before the core runs.

---
 rtl/instr_encoder_loader.sv | 155 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / program loader: validates decoded fields, packs them into
// a 32-bit word and writes it to consecutive instruction memory addresses.
module instr_encoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_FULL} state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;

  logic                legal;
  logic [31:0]         word;
  logic                accept;

  always_comb begin
    legal = 1'b0;
    word  = 32'd0;
    case (in_fmt)
      2'd0: begin
        legal = (in_op == 6'b000000);
        word  = {in_op, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      end
      2'd1: begin
        legal = in_op inside {6'b000010, 6'b000011, 6'b000100, 6'b000101,
                              6'b001000, 6'b001001, 6'b010000, 6'b010001,
                              6'b000111, 6'b100011, 6'b100111, 6'b100000};
        word  = {in_op, in_rs, in_rt, in_imm};
      end
      2'd2: begin
        legal = (in_op == 6'b111000) || (in_op == 6'b111001);
        word  = {in_op, in_target};
      end
      default: begin
        legal = 1'b0;
        word  = 32'd0;
      end
    endcase
  end

  // in_ready_q is only set while in RUN; start always wins over a same-cycle accept.
  assign accept = in_valid && in_ready_q && !start;

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    full_d    = full_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    if (start) begin
      state_d   = S_RUN;
      mem_req_d = 1'b0;
      full_d    = 1'b0;
      err_d     = 1'b0;
      addr_d    = base_addr;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (accept) begin
            if (legal) begin
              wdata_d   = word;
              mem_req_d = 1'b1;
              state_d   = S_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            if (&addr_q) begin
              full_d  = 1'b1;
              state_d = S_FULL;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_RUN;
            end
          end
        end
        default: ;
      endcase
    end
    in_ready_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN) || (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign full        = full_q;
  assign wr_count    = cnt_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus random
// instruction streams compared against an arithmetic encoding model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int ADDR_MAX = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [5:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              busy;
  logic              full;
  logic [ADDR_W:0]   wr_count;
  logic              err_illegal;

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .full(full), .wr_count(wr_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_addr, m_cnt, m_err, m_full;
  int i_ops[12] = '{2, 3, 4, 5, 8, 9, 16, 17, 7, 35, 39, 32};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(input int fmt, input int op);
    bit ok = 1'b0;
    if (fmt == 0) ok = (op == 0);
    else if (fmt == 1) begin
      for (int k = 0; k < 12; k++) if (i_ops[k] == op) ok = 1'b1;
    end else if (fmt == 2) ok = (op == 56) || (op == 57);
    return ok;
  endfunction

  function automatic logic [31:0] m_encode(input int fmt, input int op, input int rs,
                                           input int rt, input int rd, input int funct,
                                           input int imm, input int target);
    int unsigned w;
    w = op * 67108864;
    if (fmt == 0) w = w + rs * 2097152 + rt * 65536 + rd * 2048 + funct;
    else if (fmt == 1) w = w + rs * 2097152 + rt * 65536 + imm;
    else w = w + target;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    tick();
    start = 1'b0;
    m_addr = base; m_cnt = 0; m_err = 0; m_full = 0;
    chk("start_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_addr", 32'(mem_addr), m_addr);
    chk("start_count", 32'(wr_count), 0);
    chk("start_err", 32'(err_illegal), 0);
    chk("start_full", 32'(full), 0);
  endtask

  // ack_delay < 0 leaves a legal write pending in WRITE.
  task automatic push(input int fmt, input int op, input int rs, input int rt, input int rd,
                      input int funct, input int imm, input int target, input int ack_delay);
    bit lg;
    logic [31:0] w;
    int waited;
    lg = m_legal(fmt, op);
    w  = m_encode(fmt, op, rs, rt, rd, funct, imm, target);
    in_fmt = 2'(fmt); in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_funct = 6'(funct); in_imm = 16'(imm); in_target = 26'(target);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("ready_wait", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    if (lg) begin
      chk("req_rise", 32'(mem_req), 1);
      chk("wr_addr", 32'(mem_addr), m_addr);
      chk("wr_data", mem_wdata, w);
      chk("wr_ready", 32'(in_ready), 0);
      if (ack_delay < 0) return;
      for (int d = 0; d < ack_delay; d++) begin
        tick();
        chk("hold_req", 32'(mem_req), 1);
        chk("hold_addr", 32'(mem_addr), m_addr);
        chk("hold_data", mem_wdata, w);
        chk("hold_ready", 32'(in_ready), 0);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      m_cnt++;
      if (m_addr == ADDR_MAX) m_full = 1; else m_addr++;
      chk("ack_req", 32'(mem_req), 0);
      chk("ack_count", 32'(wr_count), m_cnt);
      chk("ack_addr", 32'(mem_addr), m_addr);
      chk("ack_full", 32'(full), m_full);
      chk("ack_ready", 32'(in_ready), m_full ? 0 : 1);
      chk("ack_busy", 32'(busy), m_full ? 0 : 1);
    end else begin
      m_err = 1;
      chk("ill_req", 32'(mem_req), 0);
      chk("ill_err", 32'(err_illegal), 1);
      chk("ill_count", 32'(wr_count), m_cnt);
      chk("ill_ready", 32'(in_ready), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_err"}, 32'(err_illegal), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_data"}, mem_wdata, 0);
    chk({tag, "_count"}, 32'(wr_count), 0);
  endtask

  initial begin
    int fmt, op;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ack = 1'b0;
    in_fmt = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_funct = '0; in_imm = '0; in_target = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(in_ready), 0);

    // Directed encodings
    do_start('h010);
    push(0, 0, 1, 2, 3, 'h20, 0, 0, 0);
    push(1, 2, 4, 5, 0, 0, 'hFFFF, 0, 0);
    push(2, 57, 0, 0, 0, 0, 0, 'h3E8, 0);
    push(1, 56, 1, 1, 1, 0, 0, 0, 0);
    push(3, 0, 1, 1, 1, 0, 0, 0, 0);
    push(0, 0, 7, 8, 9, 1, 0, 0, 5);
    chk("sticky_err", 32'(err_illegal), 1);

    // mem_ack outside WRITE has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_count", 32'(wr_count), m_cnt);
    chk("stray_ack_addr", 32'(mem_addr), m_addr);

    // Random streams
    for (int s = 0; s < 3; s++) begin
      do_start($urandom_range(0, 'h300));
      for (int t = 0; t < 30; t++) begin
        fmt = $urandom_range(0, 3);
        if ($urandom_range(0, 9) < 7) begin
          if (fmt == 0) op = 0;
          else if (fmt == 1) op = i_ops[$urandom_range(0, 11)];
          else op = 56 + $urandom_range(0, 1);
        end else begin
          op = $urandom_range(0, 63);
        end
        push(fmt, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 67108863),
             $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) tick();
      end
      chk("rand_err", 32'(err_illegal), m_err);
      chk("rand_count", 32'(wr_count), m_cnt);
    end

    // Fill to the last address
    do_start(ADDR_MAX - 1);
    push(0, 0, 1, 2, 3, 4, 0, 0, 0);
    push(1, 35, 6, 7, 0, 0, 'h1234, 0, 1);
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(wr_count), 2);
    in_valid = 1'b1; in_fmt = 2'd0; in_op = 6'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_ready", 32'(in_ready), 0);
      chk("full_req", 32'(mem_req), 0);
      chk("full_addr", 32'(mem_addr), ADDR_MAX);
    end
    in_valid = 1'b0;

    // start mid-WRITE with coincident ack and valid
    do_start('h100);
    push(2, 56, 0, 0, 0, 0, 0, 'h55, -1);
    start = 1'b1; base_addr = ADDR_W'('h155); mem_ack = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; mem_ack = 1'b0; in_valid = 1'b0;
    chk("restart_req", 32'(mem_req), 0);
    chk("restart_addr", 32'(mem_addr), 'h155);
    chk("restart_count", 32'(wr_count), 0);
    chk("restart_full", 32'(full), 0);
    chk("restart_ready", 32'(in_ready), 1);
    tick();
    chk("restart_noaccept", 32'(mem_req), 0);
    m_addr = 'h155; m_cnt = 0; m_err = 0; m_full = 0;
    push(0, 0, 3, 3, 3, 3, 0, 0, 0);

    // Asynchronous reset mid-WRITE
    push(1, 8, 2, 2, 0, 0, 'h7777, 0, -1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
